// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of a single memory bus, with a
// mandatory idle bubble between transactions and a per-transaction timeout.
module bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_we,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ready,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_we,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ready,
  output logic              s_valid,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic              s_we,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_ready,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [15:0]       TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] TMO_DATA = DATA_W'(32'hDEAD_BEEF);

  state_t      r_state;
  logic [1:0]  r_grant;
  logic        r_last_grant;
  logic [15:0] r_cnt;

  logic              w_busy;
  logic              w_sel;
  logic              w_tmo;
  logic              w_done;
  logic [DATA_W-1:0] w_rdata;

  assign w_busy = (r_state == BUSY);
  assign w_sel  = r_grant[1];
  // s_ready takes priority over an expiring timeout in the same cycle.
  assign w_tmo  = w_busy & ~s_ready & (r_cnt == TMO_LAST);
  assign w_done = w_busy & (s_ready | w_tmo);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_grant      <= 2'b00;
      r_last_grant <= 1'b1;
      r_cnt        <= 16'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= 16'd0;
          if (m0_req && m1_req) begin
            r_grant <= r_last_grant ? 2'b01 : 2'b10;
            r_state <= BUSY;
          end else if (m0_req) begin
            r_grant <= 2'b01;
            r_state <= BUSY;
          end else if (m1_req) begin
            r_grant <= 2'b10;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (w_done) begin
            r_grant      <= 2'b00;
            r_last_grant <= w_sel;
            r_state      <= IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Bus side is quiet (all zero) outside BUSY so the memory never sees stale fields.
  assign s_valid = w_busy;
  assign s_addr  = w_busy ? (w_sel ? m1_addr  : m0_addr)  : '0;
  assign s_wdata = w_busy ? (w_sel ? m1_wdata : m0_wdata) : '0;
  assign s_we    = w_busy & (w_sel ? m1_we : m0_we);

  assign w_rdata     = w_tmo ? TMO_DATA : s_rdata;
  assign m0_rdata    = r_grant[0] ? w_rdata : '0;
  assign m1_rdata    = r_grant[1] ? w_rdata : '0;
  assign m0_ready    = r_grant[0] & w_done;
  assign m1_ready    = r_grant[1] & w_done;
  assign grant       = r_grant;
  assign timeout_err = w_tmo;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios push expected completions into a
// scoreboard queue; a negedge monitor pops and checks every ready pulse.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready;
  logic        s_valid, s_we, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [1:0]  grant;
  logic        timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        mst;
    logic [31:0] data;
    logic        tmo;
  } exp_t;
  exp_t q[$];

  bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every completion strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && (m0_ready || m1_ready)) begin
      n_cmp++;
      if (m0_ready && m1_ready) begin
        n_err++;
        $display("FAIL both_ready: got m0_ready=1 m1_ready=1 expected at most one");
      end else if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_ready: got m0_ready=%0b m1_ready=%0b expected none", m0_ready, m1_ready);
      end else begin
        exp_t e;
        logic [31:0] got_d;
        e = q.pop_front();
        got_d = m1_ready ? m1_rdata : m0_rdata;
        if (m1_ready !== e.mst || got_d !== e.data || timeout_err !== e.tmo) begin
          n_err++;
          $display("FAIL completion: got mst=%0d data=%h tmo=%0b expected mst=%0d data=%h tmo=%0b",
                   m1_ready, got_d, timeout_err, e.mst, e.data, e.tmo);
        end else begin
          $display("txn: m%0d data=%h tmo=%0b ok", e.mst, e.data, e.tmo);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    s_ready = 0; s_rdata = 0;
    repeat (2) tick();
    n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL reset_grant: got %b expected 00", grant); end
    n_cmp++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL reset_s_valid: got %b expected 0", s_valid); end
    n_cmp++; if ({m0_ready, m1_ready, timeout_err} !== 3'b000) begin n_err++; $display("FAIL reset_strobes: got %b expected 000", {m0_ready, m1_ready, timeout_err}); end
    n_cmp++; if (s_addr !== 32'h0) begin n_err++; $display("FAIL reset_s_addr: got %h expected 0", s_addr); end
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    tick();
    m0_req = 1; m0_addr = 32'h100; m0_we = 0;
    tick();
    n_cmp++; if (grant !== 2'b01) begin n_err++; $display("FAIL read_grant: got %b expected 01", grant); end
    n_cmp++; if (s_valid !== 1'b1 || s_addr !== 32'h100 || s_we !== 1'b0) begin n_err++; $display("FAIL read_bus: got v=%b a=%h we=%b expected v=1 a=100 we=0", s_valid, s_addr, s_we); end
    s_rdata = 32'h1234_5678; s_ready = 1;
    q.push_back('{1'b0, 32'h1234_5678, 1'b0});
    #1;
    n_cmp++; if (m0_rdata !== 32'h1234_5678 || m1_rdata !== 32'h0) begin n_err++; $display("FAIL read_rdata: got m0=%h m1=%h expected m0=12345678 m1=0", m0_rdata, m1_rdata); end
    tick();
    s_ready = 0; m0_req = 0;
    n_cmp++; if (grant !== 2'b00 || s_valid !== 1'b0) begin n_err++; $display("FAIL read_idle: got grant=%b v=%b expected 00 0", grant, s_valid); end
  endtask

  task automatic test_tie();
    logic [1:0] exp_g;
    reset = 1; tick(); reset = 0;
    m0_req = 1; m1_req = 1; m0_addr = 32'h10; m1_addr = 32'h20;
    for (int i = 0; i < 3; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      n_cmp++; if (grant !== exp_g) begin n_err++; $display("FAIL tie_grant%0d: got %b expected %b", i, grant, exp_g); end
      n_cmp++; if (s_addr !== (exp_g[1] ? 32'h20 : 32'h10)) begin n_err++; $display("FAIL tie_addr%0d: got %h", i, s_addr); end
      s_rdata = 32'h1000 + i; s_ready = 1;
      q.push_back('{exp_g[1], 32'h1000 + i, 1'b0});
      #1;
      n_cmp++; if ((exp_g[1] ? m0_rdata : m1_rdata) !== 32'h0) begin n_err++; $display("FAIL tie_other_rdata%0d: got %h expected 0", i, exp_g[1] ? m0_rdata : m1_rdata); end
      tick();
      s_ready = 0;
      n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL tie_bubble%0d: got %b expected 00", i, grant); end
    end
    m0_req = 0; m1_req = 0;
  endtask

  // Four BUSY cycles with TIMEOUT=4: s_ready in the last one coincides with expiry.
  task automatic test_write_wait();
    m1_req = 1; m1_we = 1; m1_addr = 32'h200; m1_wdata = 32'hCAFE_F00D;
    tick();
    for (int c = 1; c <= 4; c++) begin
      n_cmp++; if (s_we !== 1'b1 || s_addr !== 32'h200 || s_wdata !== 32'hCAFE_F00D || grant !== 2'b10) begin
        n_err++; $display("FAIL write_bus_c%0d: got we=%b a=%h d=%h g=%b", c, s_we, s_addr, s_wdata, grant); end
      n_cmp++; if (m0_ready !== 1'b0) begin n_err++; $display("FAIL write_m0_ready_c%0d: got %b expected 0", c, m0_ready); end
      if (c == 4) begin
        s_rdata = 32'h5A5A_0004; s_ready = 1;
        q.push_back('{1'b1, 32'h5A5A_0004, 1'b0});
        #1;
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL coincide_tmo: got %b expected 0", timeout_err); end
      end
      tick();
    end
    s_ready = 0; m1_req = 0; m1_we = 0;
    n_cmp++; if (s_we !== 1'b0 || s_valid !== 1'b0) begin n_err++; $display("FAIL write_idle: got we=%b v=%b expected 0 0", s_we, s_valid); end
  endtask

  task automatic test_timeout();
    m0_req = 1; m0_addr = 32'h300; s_rdata = 32'h1111_1111;
    tick();
    for (int c = 1; c <= 4; c++) begin
      if (c < 4) begin
        n_cmp++; if (timeout_err !== 1'b0 || m0_ready !== 1'b0) begin n_err++; $display("FAIL tmo_early_c%0d: got err=%b rdy=%b expected 0 0", c, timeout_err, m0_ready); end
      end else begin
        q.push_back('{1'b0, 32'hDEAD_BEEF, 1'b1});
        n_cmp++; if (timeout_err !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL tmo_fire: got err=%b rdata=%h expected 1 deadbeef", timeout_err, m0_rdata); end
      end
      tick();
    end
    n_cmp++; if (timeout_err !== 1'b0 || s_valid !== 1'b0) begin n_err++; $display("FAIL tmo_after: got err=%b v=%b expected 0 0", timeout_err, s_valid); end
    m1_req = 1;
    tick();
    n_cmp++; if (grant !== 2'b10) begin n_err++; $display("FAIL tmo_rr_grant: got %b expected 10", grant); end
    s_rdata = 32'h77; s_ready = 1;
    q.push_back('{1'b1, 32'h77, 1'b0});
    tick();
    s_ready = 0; m0_req = 0; m1_req = 0;
  endtask

  task automatic test_reset_busy();
    m0_req = 1;
    tick();
    s_rdata = 32'hAB; s_ready = 1;
    q.push_back('{1'b0, 32'hAB, 1'b0});
    tick();
    s_ready = 0; m0_req = 0; m1_req = 1;
    tick();
    n_cmp++; if (grant !== 2'b10) begin n_err++; $display("FAIL rb_grant: got %b expected 10", grant); end
    tick();
    reset = 1;
    #1;
    n_cmp++; if (s_valid !== 1'b0 || grant !== 2'b00) begin n_err++; $display("FAIL rb_async: got v=%b g=%b expected 0 00", s_valid, grant); end
    n_cmp++; if (m1_ready !== 1'b0 || m0_ready !== 1'b0) begin n_err++; $display("FAIL rb_ready: got m0=%b m1=%b expected 0 0", m0_ready, m1_ready); end
    m0_req = 1;
    tick();
    reset = 0;
    tick();
    n_cmp++; if (grant !== 2'b01) begin n_err++; $display("FAIL rb_tie_after: got %b expected 01", grant); end
    s_rdata = 32'hCD; s_ready = 1;
    q.push_back('{1'b0, 32'hCD, 1'b0});
    tick();
    s_ready = 0; m0_req = 0; m1_req = 0;
  endtask

  task automatic test_idle_sready();
    s_ready = 1; s_rdata = 32'hFFFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (s_valid !== 1'b0 || grant !== 2'b00 || m0_ready !== 1'b0 || m1_ready !== 1'b0 || m0_rdata !== 32'h0) begin
        n_err++; $display("FAIL idle_sready_c%0d: got v=%b g=%b r0=%b r1=%b d0=%h", c, s_valid, grant, m0_ready, m1_ready, m0_rdata); end
    end
    s_ready = 0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_write_wait();
    test_timeout();
    test_reset_busy();
    test_idle_sready();
    repeat (2) tick();
    n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
